// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg
//   Shared types and default sizes for the layer sequencer slice.
//   - seq_state_t : sequencer FSM state encoding
//   - LS_*        : default width / depth localparams
//   - layer_cfg_t : packed per-layer configuration entry, MSB first in
//                   the same order as the cfg_wdata bus
package layer_seq_pkg;

    localparam int LS_MAX_LAYER = 16;
    localparam int LS_SIZE_W    = 9;
    localparam int LS_CH_W      = 11;
    localparam int LS_ADDR_W    = 22;
    localparam int LS_CFG_W     = LS_SIZE_W + 2*LS_CH_W + 6 + 2*LS_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FIN   = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [LS_SIZE_W-1:0] ifm_size;
        logic [LS_CH_W-1:0]   ifm_channel;
        logic [1:0]           kernel_size;
        logic [LS_CH_W-1:0]   num_filter;
        logic                 maxpool_mode;
        logic [1:0]           maxpool_stride;
        logic                 upsample_mode;
        logic [LS_ADDR_W-1:0] start_write_addr;
        logic [LS_ADDR_W-1:0] start_read_addr;
    } layer_cfg_t;

endpackage

// File: rtl/layer_cfg_table.sv
// layer_cfg_table
//   MAX_LAYER x CFG_W register file holding the per-layer configuration.
//   Synchronous write, combinational read. A read of the entry being
//   written in the same cycle returns the incoming data. Synchronous
//   clear of every entry on rst.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   we, wr_idx, wdata write port
//   rd_idx, rd_data   read port
module layer_cfg_table
    import layer_seq_pkg::*;
#(
    parameter int MAX_LAYER = LS_MAX_LAYER,
    parameter int CFG_W     = LS_CFG_W,
    parameter int IDX_W     = $clog2(MAX_LAYER)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [CFG_W-1:0] wdata,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CFG_W-1:0] rd_data
);

    logic [CFG_W-1:0] mem [MAX_LAYER];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LAYER; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_idx] <= wdata;
        end
    end

    assign rd_data = (we && (wr_idx == rd_idx)) ? wdata : mem[rd_idx];

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Steps through the first num_layer entries of a run-time programmable
//   layer configuration table. For each layer the entry is registered onto
//   the config outputs, start_layer pulses, and the sequencer waits for
//   done_layer. Supports abort and reports illegal requests on cfg_err.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   cfg_we/idx/wdata      table write port (accepted only when idle)
//   num_layer, start_cnn  run request
//   abort                 cancel the current run
//   done_layer            datapath layer-complete pulse
//   start_layer, done_cnn one-cycle pulses
//   busy, cfg_err         status
//   count_layer           1-based current layer, 0 when idle
//   ifm_size..start_read_addr  registered config of the current layer
//
// Optional feature: define LAYER_PERF_EN to add a per-layer cycle counter
// with outputs layer_cycles[31:0] and perf_valid.
//
// state | meaning
// IDLE  | no run; table writable
// LOAD  | register table[idx] onto config outputs
// ISSUE | pulse start_layer
// WAIT  | wait for done_layer
// FIN   | pulse done_cnn, then back to IDLE
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int MAX_LAYER = LS_MAX_LAYER,
    parameter int SIZE_W    = LS_SIZE_W,
    parameter int CH_W      = LS_CH_W,
    parameter int ADDR_W    = LS_ADDR_W,
    parameter int CFG_W     = SIZE_W + 2*CH_W + 6 + 2*ADDR_W,
    parameter int IDX_W     = $clog2(MAX_LAYER),
    parameter int NL_W      = $clog2(MAX_LAYER+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [CFG_W-1:0]  cfg_wdata,
    input  logic [NL_W-1:0]   num_layer,
    input  logic              start_cnn,
    input  logic              abort,
    input  logic              done_layer,
    output logic              start_layer,
    output logic              done_cnn,
    output logic              busy,
    output logic              cfg_err,
    output logic [NL_W-1:0]   count_layer,
    output logic [SIZE_W-1:0] ifm_size,
    output logic [CH_W-1:0]   ifm_channel,
    output logic [1:0]        kernel_size,
    output logic [CH_W-1:0]   num_filter,
    output logic              maxpool_mode,
    output logic [1:0]        maxpool_stride,
    output logic              upsample_mode,
    output logic [ADDR_W-1:0] start_write_addr,
    output logic [ADDR_W-1:0] start_read_addr
`ifdef LAYER_PERF_EN
    ,
    output logic [31:0]       layer_cycles,
    output logic              perf_valid
`endif
);

    // Field offsets inside a packed entry, LSB upwards.
    localparam int RD_LSB  = 0;
    localparam int WR_LSB  = RD_LSB + ADDR_W;
    localparam int UP_LSB  = WR_LSB + ADDR_W;
    localparam int MPS_LSB = UP_LSB + 1;
    localparam int MPM_LSB = MPS_LSB + 2;
    localparam int NF_LSB  = MPM_LSB + 1;
    localparam int K_LSB   = NF_LSB + CH_W;
    localparam int CH_LSB  = K_LSB + 2;
    localparam int SZ_LSB  = CH_LSB + CH_W;

    seq_state_t       state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [NL_W-1:0]  num_layer_q;
    logic [CFG_W-1:0] cfg_q;
    logic [CFG_W-1:0] tbl_rd_data;
    logic             tbl_we;
    logic             nl_legal;
    logic             run_req;
    logic             last_layer;
    logic             abort_run;

    assign nl_legal   = (num_layer != '0) && (int'(num_layer) <= MAX_LAYER);
    assign run_req    = (state == ST_IDLE) && start_cnn;
    assign last_layer = (count_layer == num_layer_q);
    assign abort_run  = abort && (state != ST_IDLE);
    assign tbl_we     = cfg_we && (state == ST_IDLE);

    layer_cfg_table #(
        .MAX_LAYER (MAX_LAYER),
        .CFG_W     (CFG_W),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .we      (tbl_we),
        .wr_idx  (cfg_idx),
        .wdata   (cfg_wdata),
        .rd_idx  (idx),
        .rd_data (tbl_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_cnn && nl_legal) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (done_layer) state_nxt = last_layer ? ST_FIN : ST_LOAD;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        // Abort overrides everything, including a coincident done_layer.
        if (abort_run) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        start_layer = 1'b0;
        done_cnn    = 1'b0;
        busy        = 1'b1;
        case (state)
            ST_IDLE:  busy        = 1'b0;
            ST_ISSUE: start_layer = 1'b1;
            ST_FIN:   done_cnn    = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            num_layer_q <= '0;
            cfg_q       <= '0;
            count_layer <= '0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= (run_req && !nl_legal) || (cfg_we && (state != ST_IDLE));
            if (run_req && nl_legal) begin
                num_layer_q <= num_layer;
                idx         <= '0;
            end
            if (abort_run) begin
                cfg_q       <= '0;
                count_layer <= '0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        cfg_q       <= tbl_rd_data;
                        count_layer <= NL_W'(idx) + NL_W'(1);
                    end
                    ST_WAIT: begin
                        if (done_layer && !last_layer) begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                    ST_FIN: begin
                        cfg_q       <= '0;
                        count_layer <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ifm_size         = cfg_q[SZ_LSB  +: SIZE_W];
    assign ifm_channel      = cfg_q[CH_LSB  +: CH_W];
    assign kernel_size      = cfg_q[K_LSB   +: 2];
    assign num_filter       = cfg_q[NF_LSB  +: CH_W];
    assign maxpool_mode     = cfg_q[MPM_LSB];
    assign maxpool_stride   = cfg_q[MPS_LSB +: 2];
    assign upsample_mode    = cfg_q[UP_LSB];
    assign start_write_addr = cfg_q[WR_LSB  +: ADDR_W];
    assign start_read_addr  = cfg_q[RD_LSB  +: ADDR_W];

`ifdef LAYER_PERF_EN
    // Counts ISSUE and WAIT cycles; the result includes the cycle in which
    // done_layer is sampled, so it is published as count+1.
    logic [31:0] perf_cnt;
    logic [31:0] perf_cnt_inc;

    assign perf_cnt_inc = (perf_cnt == 32'hFFFF_FFFF) ? perf_cnt : perf_cnt + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt     <= '0;
            layer_cycles <= '0;
            perf_valid   <= 1'b0;
        end else begin
            perf_valid <= 1'b0;
            if (abort_run) begin
                perf_cnt     <= '0;
                layer_cycles <= '0;
            end else begin
                case (state)
                    ST_LOAD:  perf_cnt <= '0;
                    ST_ISSUE: perf_cnt <= perf_cnt_inc;
                    ST_WAIT: begin
                        perf_cnt <= perf_cnt_inc;
                        if (done_layer) begin
                            layer_cycles <= perf_cnt_inc;
                            perf_valid   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;
    import layer_seq_pkg::*;

    localparam int IDX_W = $clog2(LS_MAX_LAYER);
    localparam int NL_W  = $clog2(LS_MAX_LAYER+1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_we;
    logic [IDX_W-1:0]     cfg_idx;
    logic [LS_CFG_W-1:0]  cfg_wdata;
    logic [NL_W-1:0]      num_layer;
    logic                 start_cnn;
    logic                 abort;
    logic                 done_layer;
    logic                 start_layer;
    logic                 done_cnn;
    logic                 busy;
    logic                 cfg_err;
    logic [NL_W-1:0]      count_layer;
    logic [LS_SIZE_W-1:0] ifm_size;
    logic [LS_CH_W-1:0]   ifm_channel;
    logic [1:0]           kernel_size;
    logic [LS_CH_W-1:0]   num_filter;
    logic                 maxpool_mode;
    logic [1:0]           maxpool_stride;
    logic                 upsample_mode;
    logic [LS_ADDR_W-1:0] start_write_addr;
    logic [LS_ADDR_W-1:0] start_read_addr;
`ifdef LAYER_PERF_EN
    logic [31:0]          layer_cycles;
    logic                 perf_valid;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_done   = 0;
    int s_mark;
    int d_mark;

    layer_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_we           (cfg_we),
        .cfg_idx          (cfg_idx),
        .cfg_wdata        (cfg_wdata),
        .num_layer        (num_layer),
        .start_cnn        (start_cnn),
        .abort            (abort),
        .done_layer       (done_layer),
        .start_layer      (start_layer),
        .done_cnn         (done_cnn),
        .busy             (busy),
        .cfg_err          (cfg_err),
        .count_layer      (count_layer),
        .ifm_size         (ifm_size),
        .ifm_channel      (ifm_channel),
        .kernel_size      (kernel_size),
        .num_filter       (num_filter),
        .maxpool_mode     (maxpool_mode),
        .maxpool_stride   (maxpool_stride),
        .upsample_mode    (upsample_mode),
        .start_write_addr (start_write_addr),
        .start_read_addr  (start_read_addr)
`ifdef LAYER_PERF_EN
        ,
        .layer_cycles     (layer_cycles),
        .perf_valid       (perf_valid)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_layer) n_start++;
        if (done_cnn)    n_done++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LS_CFG_W-1:0] pack_cfg(input int sz, input int ch, input int k,
                                                     input int nf, input int mpm, input int mps,
                                                     input int up, input int wr, input int rd);
        layer_cfg_t c;
        c.ifm_size         = LS_SIZE_W'(sz);
        c.ifm_channel      = LS_CH_W'(ch);
        c.kernel_size      = 2'(k);
        c.num_filter       = LS_CH_W'(nf);
        c.maxpool_mode     = 1'(mpm);
        c.maxpool_stride   = 2'(mps);
        c.upsample_mode    = 1'(up);
        c.start_write_addr = LS_ADDR_W'(wr);
        c.start_read_addr  = LS_ADDR_W'(rd);
        return c;
    endfunction

    task automatic write_cfg(input int i, input logic [LS_CFG_W-1:0] d);
        cfg_idx   = IDX_W'(i);
        cfg_wdata = d;
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic check_cfg(input string tag, input int cnt, input int sz, input int ch,
                             input int k, input int nf, input int mpm, input int mps,
                             input int up, input int wr, input int rd);
        check_eq({tag, ".count"}, 64'(count_layer), 64'(cnt));
        check_eq({tag, ".size"},  64'(ifm_size), 64'(sz));
        check_eq({tag, ".ch"},    64'(ifm_channel), 64'(ch));
        check_eq({tag, ".k"},     64'(kernel_size), 64'(k));
        check_eq({tag, ".nf"},    64'(num_filter), 64'(nf));
        check_eq({tag, ".mpm"},   64'(maxpool_mode), 64'(mpm));
        check_eq({tag, ".mps"},   64'(maxpool_stride), 64'(mps));
        check_eq({tag, ".up"},    64'(upsample_mode), 64'(up));
        check_eq({tag, ".wr"},    64'(start_write_addr), 64'(wr));
        check_eq({tag, ".rd"},    64'(start_read_addr), 64'(rd));
    endtask

    task automatic pulse_done();
        done_layer = 1'b1;
        tick();
        done_layer = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_wdata = '0;
        num_layer = '0; start_cnn = 1'b0; abort = 1'b0; done_layer = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("rst.busy", 64'(busy), 0);
        check_eq("rst.start_layer", 64'(start_layer), 0);
        check_eq("rst.done_cnn", 64'(done_cnn), 0);
        check_eq("rst.cfg_err", 64'(cfg_err), 0);
        check_cfg("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Three-layer run
        write_cfg(0, pack_cfg(382, 3, 3, 16, 1, 2, 0, 0, 0));
        write_cfg(1, pack_cfg(190, 16, 3, 32, 1, 2, 0, 577600, 0));
        write_cfg(2, pack_cfg(94, 32, 3, 64, 0, 1, 1, 0, 577600));
        s_mark = n_start; d_mark = n_done;
        num_layer = 5'd3; start_cnn = 1'b1;
        tick();
        start_cnn = 1'b0;
        check_eq("run.load.busy", 64'(busy), 1);
        check_eq("run.load.start", 64'(start_layer), 0);
        tick();
        check_eq("run.l1.start", 64'(start_layer), 1);
        check_cfg("run.l1", 1, 382, 3, 3, 16, 1, 2, 0, 0, 0);
        tick();
        check_eq("run.l1.wait.start", 64'(start_layer), 0);
        repeat (3) tick();
        pulse_done();
        check_eq("run.l2.load.count", 64'(count_layer), 1);
        check_eq("run.l2.load.start", 64'(start_layer), 0);
        tick();
        check_eq("run.l2.start", 64'(start_layer), 1);
        check_cfg("run.l2", 2, 190, 16, 3, 32, 1, 2, 0, 577600, 0);
        tick();
        write_cfg(1, pack_cfg(1, 1, 1, 1, 0, 0, 0, 1, 1));
        check_eq("busywr.cfg_err", 64'(cfg_err), 1);
        tick();
        check_eq("busywr.cfg_err.clr", 64'(cfg_err), 0);
        pulse_done();
        tick();
        check_eq("run.l3.start", 64'(start_layer), 1);
        check_cfg("run.l3", 3, 94, 32, 3, 64, 0, 1, 1, 0, 577600);
        repeat (3) tick();
        pulse_done();
        check_eq("run.fin.done_cnn", 64'(done_cnn), 1);
        check_eq("run.fin.busy", 64'(busy), 1);
        tick();
        check_eq("run.idle.done_cnn", 64'(done_cnn), 0);
        check_eq("run.idle.busy", 64'(busy), 0);
        check_cfg("run.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("run.n_start", 64'(n_start - s_mark), 3);
        check_eq("run.n_done", 64'(n_done - d_mark), 1);

        // Entry 1 must still hold its pre-run value
        num_layer = 5'd2; start_cnn = 1'b1;
        tick();
        start_cnn = 1'b0;
        tick(); tick();
        pulse_done();
        tick();
        check_cfg("rdbk.l2", 2, 190, 16, 3, 32, 1, 2, 0, 577600, 0);
        tick();
        pulse_done();
        tick();

        // Write in the same cycle as start_cnn is seen by the first LOAD
        cfg_idx = '0; cfg_wdata = pack_cfg(46, 64, 1, 128, 0, 3, 1, 1000, 2000);
        cfg_we = 1'b1; num_layer = 5'd1; start_cnn = 1'b1;
        tick();
        cfg_we = 1'b0; start_cnn = 1'b0;
        tick();
        check_cfg("wrstart", 1, 46, 64, 1, 128, 0, 3, 1, 1000, 2000);
        tick();
        pulse_done();
        check_eq("wrstart.done_cnn", 64'(done_cnn), 1);
        tick();

        // Illegal layer counts
        num_layer = 5'd0; start_cnn = 1'b1;
        tick();
        start_cnn = 1'b0;
        check_eq("nl0.cfg_err", 64'(cfg_err), 1);
        check_eq("nl0.busy", 64'(busy), 0);
        tick();
        check_eq("nl0.cfg_err.clr", 64'(cfg_err), 0);
        num_layer = 5'd17; start_cnn = 1'b1;
        tick();
        start_cnn = 1'b0;
        check_eq("nl17.cfg_err", 64'(cfg_err), 1);
        check_eq("nl17.busy", 64'(busy), 0);
        tick();
        check_eq("nl17.busy2", 64'(busy), 0);

        // Abort coinciding with done_layer of layer 1
        num_layer = 5'd3; start_cnn = 1'b1;
        tick();
        start_cnn = 1'b0;
        tick(); tick(); tick();
        abort = 1'b1; done_layer = 1'b1;
        tick();
        abort = 1'b0; done_layer = 1'b0;
        check_eq("abort.busy", 64'(busy), 0);
        check_eq("abort.done_cnn", 64'(done_cnn), 0);
        check_cfg("abort", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s_mark = n_start; d_mark = n_done;
        repeat (5) tick();
        check_eq("abort.no_start", 64'(n_start - s_mark), 0);
        check_eq("abort.no_done", 64'(n_done - d_mark), 0);

        // Spurious done_layer in IDLE/ISSUE and start_cnn while busy
        pulse_done();
        check_eq("spur.idle.busy", 64'(busy), 0);
        s_mark = n_start; d_mark = n_done;
        num_layer = 5'd2; start_cnn = 1'b1;
        tick();
        start_cnn = 1'b0;
        tick();
        done_layer = 1'b1; start_cnn = 1'b1; num_layer = 5'd1;
        tick();
        done_layer = 1'b0; start_cnn = 1'b0;
        check_eq("spur.wait.busy", 64'(busy), 1);
        check_eq("spur.wait.count", 64'(count_layer), 1);
        tick();
        check_eq("spur.wait2.start", 64'(start_layer), 0);
        check_eq("spur.wait2.count", 64'(count_layer), 1);
        pulse_done();
        tick();
        check_eq("spur.l2.start", 64'(start_layer), 1);
        check_eq("spur.l2.count", 64'(count_layer), 2);
        tick();
        pulse_done();
        check_eq("spur.done_cnn", 64'(done_cnn), 1);
        tick();
        check_eq("spur.busy_end", 64'(busy), 0);
        check_eq("spur.n_start", 64'(n_start - s_mark), 2);
        check_eq("spur.n_done", 64'(n_done - d_mark), 1);

        // Reset mid-run stops the run and clears the table
        num_layer = 5'd1; start_cnn = 1'b1;
        tick();
        start_cnn = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst.busy", 64'(busy), 0);
        check_eq("midrst.count", 64'(count_layer), 0);
        num_layer = 5'd1; start_cnn = 1'b1;
        tick();
        start_cnn = 1'b0;
        tick();
        check_cfg("midrst.tbl", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        pulse_done();
        tick();

`ifdef LAYER_PERF_EN
        write_cfg(0, pack_cfg(10, 1, 1, 1, 0, 0, 0, 0, 0));
        num_layer = 5'd1; start_cnn = 1'b1;
        tick();
        start_cnn = 1'b0;
        tick();
        check_eq("perf.start", 64'(start_layer), 1);
        repeat (100) tick();
        done_layer = 1'b1;
        check_eq("perf.pre_valid", 64'(perf_valid), 0);
        tick();
        done_layer = 1'b0;
        check_eq("perf.valid", 64'(perf_valid), 1);
        check_eq("perf.cycles", 64'(layer_cycles), 101);
        tick();
        check_eq("perf.valid_clr", 64'(perf_valid), 0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Programmable, parametrised successor to the fixed-table CNN main controller. It holds a per-layer configuration table that is written at run time, then steps through the first `num_layer` entries. For each layer it presents that layer's configuration and issues a `start_layer` pulse, then waits for `done_layer`. All logic is fully synchronous, with abort and error reporting. It sits between the host/config interface and the convolution, maxpool and upsample datapath.

## Interface
- `MAX_LAYER`, 16: table depth and maximum number of layers per run.
- `SIZE_W`, 9: width of `ifm_size`.
- `CH_W`, 11: width of `ifm_channel` and `num_filter`.
- `ADDR_W`, 22: width of the OFM RAM start addresses.
- `CFG_W`, derived as SIZE_W+2*CH_W+6+2*ADDR_W: packed entry width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  table write strobe.
- `cfg_idx`  in  $clog2(MAX_LAYER)  entry index, 0-based.
- `cfg_wdata`  in  CFG_W  packed entry. Fields from MSB to LSB: ifm_size, ifm_channel, kernel_size[2], num_filter, maxpool_mode[1], maxpool_stride[2], upsample_mode[1], start_write_addr, start_read_addr.
- `num_layer`  in  $clog2(MAX_LAYER+1)  number of layers in the run; sampled on `start_cnn`.
- `start_cnn`  in  1  run request.
- `abort`  in  1  cancel the run.
- `done_layer`  in  1  datapath layer-complete pulse.
- `start_layer`  out  1  one-cycle layer start pulse.
- `done_cnn`  out  1  one-cycle run-complete pulse.
- `busy`  out  1  high whenever the state is not IDLE.
- `cfg_err`  out  1  one-cycle illegal-request pulse.
- `count_layer`  out  $clog2(MAX_LAYER+1)  1-based number of the current layer; 0 when idle.
- `ifm_size`, `ifm_channel`, `kernel_size`, `num_filter`, `maxpool_mode`, `maxpool_stride`, `upsample_mode`, `start_write_addr`, `start_read_addr`  out  field widths  registered configuration of the current layer.

## Operation
- FSM states: IDLE, LOAD, ISSUE, WAIT, FIN.
  - IDLE to LOAD: on `start_cnn` when 1 ≤ `num_layer` ≤ MAX_LAYER. The sequencer latches `num_layer` and clears the layer index.
  - IDLE with `start_cnn` and an illegal `num_layer` (0 or above MAX_LAYER): pulse `cfg_err` and stay in IDLE.
  - LOAD: register table[idx] onto the config outputs and set `count_layer`=idx+1. Go to ISSUE.
  - ISSUE: assert `start_layer` for one cycle. Go to WAIT.
  - WAIT: on `done_layer`, go to FIN if `count_layer`==latched `num_layer`; otherwise increment idx and go to LOAD.
  - FIN: assert `done_cnn` for one cycle. Go to IDLE, clearing `count_layer` and all config outputs to 0.
- Config outputs stay stable from LOAD until the next LOAD or until IDLE.
- Table access:
  - Writes are accepted only in IDLE.
  - `cfg_we` while busy: the write is dropped and `cfg_err` pulses.
  - A write in the same cycle as `start_cnn` is committed first, so the following LOAD sees the new data.
- Ignored inputs:
  - `done_layer` outside WAIT.
  - `start_cnn` while busy.
- `abort` in any non-IDLE state: go to IDLE next cycle, with no `done_cnn`, `count_layer`=0 and outputs cleared. If `abort` and `done_layer` arrive together, `abort` wins.
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - All table entries are cleared to 0.
  - Reset asserted mid-run has the same effect as `abort` and also clears the table.

## Timing
- `start_cnn` sampled at cycle 0 → LOAD at 1 → config and `count_layer` valid at 2 → `start_layer` high at 2.
- Config therefore precedes or coincides with `start_layer`; it is never later.
- `done_layer` at cycle t → next layer's config valid and `start_layer` high at t+2.
- Last layer: `done_layer` at t → `done_cnn` high at t+1 → `busy` low at t+2.
- `cfg_err` appears one cycle after the offending request.

## Configuration
- `LAYER_PERF_EN` defined:
  - A 32-bit cycle counter runs from the `start_layer` cycle to the cycle `done_layer` is sampled, inclusive.
  - It drives added outputs `layer_cycles[31:0]` and `perf_valid`; `perf_valid` pulses one cycle after `done_layer`.
  - The counter saturates at 0xFFFFFFFF and clears on LOAD, `abort` and `rst`.
- `LAYER_PERF_EN` undefined: no counter; the ports `layer_cycles` and `perf_valid` are absent.

## Structure
- Package `layer_seq_pkg` holds:
  - the FSM state enum;
  - the default width localparams;
  - a packed `layer_cfg_t` struct matching the `cfg_wdata` field order.
- Sub-module `layer_cfg_table`:
  - MAX_LAYER × CFG_W register file;
  - synchronous write with write-over-read forwarding;
  - combinational read;
  - synchronous clear on `rst`.

## Test plan
- Write 3 entries (entry 0: ifm_size 382, ch 3, k 3, nf 16, wr 0; entry 1: 190/16/3/32, wr 577600; entry 2: 94/32/3/64), `num_layer`=3, `start_cnn` → exactly 3 `start_layer` pulses, `count_layer` 1,2,3 with matching fields, `done_cnn` one cycle after the third `done_layer`.
- `num_layer`=0 and then `num_layer`=MAX_LAYER+1 → `cfg_err` pulses both times, `busy` stays 0.
- `cfg_we` during WAIT of layer 2 → `cfg_err` pulses and a table read-back after the run shows the old value.
- `abort` in the same cycle as `done_layer` of layer 1 → IDLE next cycle, no further `start_layer`, no `done_cnn`, outputs 0.
- Spurious `done_layer` in IDLE and ISSUE, plus `start_cnn` while busy → no state change, no extra pulses.
- With `LAYER_PERF_EN`: `done_layer` 100 cycles after `start_layer` → `layer_cycles`=101 with `perf_valid` one cycle later.
